sound_mailbox_68k: RTL and testbench

- 68000-side end of the sound CPU command/reply mailbox; the NEO-C1 sound-latch function as synchronous logic.
- Latches the 8-bit command written by the 68k and generates the nSDW strobe that arms the Z80 NMI.
- Serves the command to the Z80 on port reads and honours the Z80 command-clear.
- Captures the Z80 reply byte and exposes pending/new flags to the 68k.

---
 rtl/sound_mailbox_68k_if.sv | 27 ++
 rtl/sound_mailbox_68k.sv | 141 ++++++++++++++
 tb/tb_sound_mailbox_68k.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sound_mailbox_68k_if.sv
// 68k/Z80 sound mailbox bus bundle.
// The slave modport faces the mailbox; the master modport drives it.
interface sound_mailbox_68k_if;
   logic       M68K_CMD_WR;
   logic [7:0] M68K_DIN;
   logic       M68K_REPLY_RD;
   logic [7:0] M68K_REPLY;
   logic [2:0] M68K_STATUS;
   logic       nSDW;
   logic       nSDZ80R;
   logic       nSDZ80W;
   logic       nSDZ80CLR;
   logic [7:0] SDD_IN;
   logic [7:0] SDD_OUT;

   modport slave (
      input  M68K_CMD_WR, M68K_DIN, M68K_REPLY_RD,
      input  nSDZ80R, nSDZ80W, nSDZ80CLR, SDD_IN,
      output M68K_REPLY, M68K_STATUS, nSDW, SDD_OUT
   );

   modport master (
      output M68K_CMD_WR, M68K_DIN, M68K_REPLY_RD,
      output nSDZ80R, nSDZ80W, nSDZ80CLR, SDD_IN,
      input  M68K_REPLY, M68K_STATUS, nSDW, SDD_OUT
   );
endinterface

// File: rtl/sound_mailbox_68k.sv
// 68k-side sound command/reply mailbox with nSDW strobe generator.
// Optional unread-command timeout: define SOUND_MAILBOX_TIMEOUT_EN.
module sound_mailbox_68k #(
   parameter int unsigned SDW_PULSE = 4
`ifdef SOUND_MAILBOX_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
   input logic                  CLK,
   input logic                  nRESET,
   sound_mailbox_68k_if.slave   bus
);

   typedef enum logic {IDLE, PULSE} state_e;

   localparam logic [7:0] CNT_LOAD = 8'(SDW_PULSE - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] reply_q, reply_d;
   logic       pend_q, pend_d;
   logic       rnew_q, rnew_d;
   logic       rd_q, rd_prev_q;
   logic       wr_q, wr_prev_q;
   logic       clr_q;
   logic [7:0] sdd_q;
   logic       rd_fall;
   logic       wr_rise;
   logic       timeout;

   assign rd_fall = rd_prev_q & ~rd_q;
   assign wr_rise = ~wr_prev_q & wr_q;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         rd_q      <= 1'b1;
         rd_prev_q <= 1'b1;
         wr_q      <= 1'b1;
         wr_prev_q <= 1'b1;
         clr_q     <= 1'b1;
         sdd_q     <= 8'h00;
      end else begin
         rd_q      <= bus.nSDZ80R;
         rd_prev_q <= rd_q;
         wr_q      <= bus.nSDZ80W;
         wr_prev_q <= wr_q;
         clr_q     <= bus.nSDZ80CLR;
         sdd_q     <= bus.SDD_IN;
      end
   end

   // A 68k write beats a coincident clear or Z80 read.
   always_comb begin
      cmd_d   = cmd_q;
      pend_d  = pend_q;
      reply_d = reply_q;
      rnew_d  = rnew_q;
      if (bus.M68K_CMD_WR) cmd_d = bus.M68K_DIN;
      else if (!clr_q)     cmd_d = 8'h00;
      if (bus.M68K_CMD_WR) pend_d = 1'b1;
      else if (rd_fall)    pend_d = 1'b0;
      if (!wr_q) reply_d = sdd_q;
      if (wr_rise)                 rnew_d = 1'b1;
      else if (bus.M68K_REPLY_RD)  rnew_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.M68K_CMD_WR) begin
               state_d = PULSE;
               cnt_d   = CNT_LOAD;
            end
         end
         PULSE: begin
            if (bus.M68K_CMD_WR) cnt_d = CNT_LOAD;
            else if (cnt_q == 8'd0) state_d = IDLE;
            else cnt_d = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         cmd_q   <= 8'h00;
         pend_q  <= 1'b0;
         reply_q <= 8'h00;
         rnew_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         pend_q  <= pend_d;
         reply_q <= reply_d;
         rnew_q  <= rnew_d;
      end
   end

`ifdef SOUND_MAILBOX_TIMEOUT_EN
   localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYC);

   logic [15:0] tcnt_q, tcnt_d;
   logic        tout_q, tout_d;

   // A fresh command restarts the unread interval.
   always_comb begin
      tcnt_d = tcnt_q;
      tout_d = tout_q;
      if (!pend_q || bus.M68K_CMD_WR) tcnt_d = 16'd0;
      else if (tcnt_q != TO_MAX)      tcnt_d = tcnt_q + 16'd1;
      if (bus.M68K_CMD_WR)            tout_d = 1'b0;
      else if (tcnt_d == TO_MAX)      tout_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         tcnt_q <= 16'd0;
         tout_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tout_q <= tout_d;
      end
   end

   assign timeout = tout_q;
`else
   assign timeout = 1'b0;
`endif

   assign bus.SDD_OUT     = cmd_q;
   assign bus.M68K_REPLY  = reply_q;
   assign bus.M68K_STATUS = {timeout, rnew_q, pend_q};
   assign bus.nSDW        = (state_q == IDLE);

endmodule

// File: tb/tb_sound_mailbox_68k.sv
// Directed vector bench for sound_mailbox_68k.
// Define SOUND_MAILBOX_TIMEOUT_EN to also exercise the timeout.
module tb_sound_mailbox_68k;

   logic CLK = 1'b0;
   logic nRESET = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   sound_mailbox_68k_if mb ();

   always #5 CLK = ~CLK;

`ifdef SOUND_MAILBOX_TIMEOUT_EN
   sound_mailbox_68k #(.SDW_PULSE(4), .TIMEOUT_CYC(10)) dut (
      .CLK(CLK), .nRESET(nRESET), .bus(mb.slave));
`else
   sound_mailbox_68k #(.SDW_PULSE(4)) dut (
      .CLK(CLK), .nRESET(nRESET), .bus(mb.slave));
`endif

   typedef struct {
      logic       wr;
      logic [7:0] din;
      logic       rrd;
      logic       rdn;
      logic       wrn;
      logic       clrn;
      logic [7:0] sdd;
      logic [7:0] e_sdd;
      logic [7:0] e_rep;
      logic [2:0] e_st;
      logic       e_nsdw;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic wr, input logic [7:0] din,
                      input logic rrd, input logic rdn,
                      input logic wrn, input logic clrn,
                      input logic [7:0] sdd,
                      input logic [7:0] es, input logic [7:0] er,
                      input logic [2:0] est, input logic en);
      vec_t v;
      v.wr = wr; v.din = din; v.rrd = rrd; v.rdn = rdn;
      v.wrn = wrn; v.clrn = clrn; v.sdd = sdd;
      v.e_sdd = es; v.e_rep = er; v.e_st = est; v.e_nsdw = en;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] got,
                      input logic [7:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [7:0] din,
                        input logic rrd, input logic rdn,
                        input logic wrn, input logic clrn,
                        input logic [7:0] sdd);
      mb.M68K_CMD_WR   = wr;
      mb.M68K_DIN      = din;
      mb.M68K_REPLY_RD = rrd;
      mb.nSDZ80R       = rdn;
      mb.nSDZ80W       = wrn;
      mb.nSDZ80CLR     = clrn;
      mb.SDD_IN        = sdd;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " sdd_out"}, mb.SDD_OUT, 8'h00);
      chk({tag, " reply"}, mb.M68K_REPLY, 8'h00);
      chk({tag, " status"}, {5'd0, mb.M68K_STATUS}, 8'h00);
      chk({tag, " nsdw"}, {7'd0, mb.nSDW}, 8'h01);
   endtask

   initial begin
      //   wr din   rrd rdn wrn clr sdd    sdd_o  rep    st     nsdw
      add(1, 8'h5A, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b001, 0); // 0
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b001, 1);
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b001, 1); // 5
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b000, 1);
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b000, 1);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h00, 3'b000, 1);
      add(0, 8'h00, 0, 1, 0, 1, 8'h33, 8'h5A, 8'h00, 3'b000, 1);
      add(0, 8'h00, 0, 1, 0, 1, 8'h44, 8'h5A, 8'h33, 3'b000, 1); // 10
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h44, 3'b000, 1);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h5A, 8'h44, 3'b010, 1);
      add(0, 8'h00, 1, 1, 1, 1, 8'h00, 8'h5A, 8'h44, 3'b000, 1);
      add(0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h5A, 8'h44, 3'b000, 1);
      add(1, 8'h12, 0, 1, 1, 1, 8'h00, 8'h12, 8'h44, 3'b001, 0); // 15
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h12, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h12, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h12, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h12, 8'h44, 3'b001, 1);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h00, 8'h44, 3'b001, 1); // 20
      add(1, 8'h77, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 0);
      add(1, 8'h77, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 0); // 25
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 1);
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 8'h77, 8'h44, 3'b001, 1);
      add(1, 8'hA5, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h44, 3'b001, 0); // 30
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h44, 3'b001, 0);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h44, 3'b001, 1);
      add(0, 8'h00, 0, 1, 0, 1, 8'h9C, 8'hA5, 8'h44, 3'b001, 1);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h9C, 3'b001, 1); // 35
      add(0, 8'h00, 1, 1, 1, 1, 8'h00, 8'hA5, 8'h9C, 3'b011, 1);
      add(0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hA5, 8'h9C, 3'b011, 1);
      add(0, 8'h00, 1, 1, 1, 1, 8'h00, 8'hA5, 8'h9C, 3'b001, 1);

      idle();
      nRESET = 1'b0;
      #1;
      chk_reset("reset");
      step();
      step();
      nRESET = 1'b1;
      step();
      chk_reset("post-reset");

      foreach (tv[i]) begin
         drive(tv[i].wr, tv[i].din, tv[i].rrd, tv[i].rdn,
               tv[i].wrn, tv[i].clrn, tv[i].sdd);
         step();
         chk($sformatf("v%0d sdd_out", i), mb.SDD_OUT, tv[i].e_sdd);
         chk($sformatf("v%0d reply", i), mb.M68K_REPLY, tv[i].e_rep);
         chk($sformatf("v%0d status", i), {5'd0, mb.M68K_STATUS},
             {5'd0, tv[i].e_st});
         chk($sformatf("v%0d nsdw", i), {7'd0, mb.nSDW},
             {7'd0, tv[i].e_nsdw});
      end

      // Asynchronous reset in the middle of a strobe
      drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      step();
      idle();
      step();
      chk("midpulse nsdw low", {7'd0, mb.nSDW}, 8'h00);
      nRESET = 1'b0;
      #1;
      chk_reset("midpulse reset");
      @(negedge CLK);
      nRESET = 1'b1;
      step();
      chk_reset("after midpulse");

`ifdef SOUND_MAILBOX_TIMEOUT_EN
      drive(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      step();
      idle();
      for (int k = 1; k <= 9; k++) step();
      chk("timeout at 9", {7'd0, mb.M68K_STATUS[2]}, 8'h00);
      step();
      chk("timeout at 10", {7'd0, mb.M68K_STATUS[2]}, 8'h01);
      step();
      step();
      chk("timeout sticky", {7'd0, mb.M68K_STATUS[2]}, 8'h01);
      drive(1'b1, 8'h82, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      step();
      idle();
      chk("timeout cleared", {7'd0, mb.M68K_STATUS[2]}, 8'h00);
      chk("timeout sdd_out", mb.SDD_OUT, 8'h82);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
